// File: rtl/rv32im_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer.
//   fetch_state_e   : 2-bit fetch FSM encoding
//   API_NOP         : instruction presented to decode out of reset (addi x0,x0,0)
//   API_INSTR_WIDTH : instruction word width
package rv32im_fetch_ctrl_pkg;

  localparam int          API_INSTR_WIDTH = 32;
  localparam logic [31:0] API_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'b00,
    FETCH_REQ   = 2'b01,
    FETCH_WAIT  = 2'b10,
    FETCH_VALID = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/rv32im_fetch_ctrl_if.sv
// Instruction-memory request/response bus.
//   req/addr : fetch request and word address, held until gnt
//   gnt      : request accepted this cycle
//   rvalid   : response valid, rdata carries the instruction
// master = fetch sequencer, slave = instruction memory.
interface rv32im_fetch_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  import rv32im_fetch_ctrl_pkg::*;

  logic                       req;
  logic [PC_WIDTH-1:0]        addr;
  logic                       gnt;
  logic                       rvalid;
  logic [API_INSTR_WIDTH-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/rv32im_redirect_arb.sv
// Redirect arbitration: trap beats branch/jump in the same cycle, target is
// forced word aligned. Also holds one pending redirect for cases where the
// fetch FSM cannot take the target immediately.
//   redirect_now_o : some redirect requested this cycle
//   target_pc_o    : aligned target of this cycle's redirect
//   capture_i      : store this cycle's redirect as pending (newer overwrites)
//   clear_i        : drop the pending redirect
//   pending_*_o    : the stored redirect
module rv32im_redirect_arb #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                trap_valid_i,
  input  logic [PC_WIDTH-1:0] trap_pc_i,
  input  logic                capture_i,
  input  logic                clear_i,
  output logic                redirect_now_o,
  output logic [PC_WIDTH-1:0] target_pc_o,
  output logic                pending_valid_o,
  output logic [PC_WIDTH-1:0] pending_pc_o
);

  logic                pending_valid_q, pending_valid_d;
  logic [PC_WIDTH-1:0] pending_pc_q, pending_pc_d;

  always_comb begin
    redirect_now_o = trap_valid_i | redirect_valid_i;
    target_pc_o    = trap_valid_i ? trap_pc_i : redirect_pc_i;
    target_pc_o[1:0] = 2'b00;
  end

  always_comb begin
    pending_valid_d = pending_valid_q;
    pending_pc_d    = pending_pc_q;
    if (capture_i && redirect_now_o) begin
      pending_valid_d = 1'b1;
      pending_pc_d    = target_pc_o;
    end else if (clear_i) begin
      pending_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_valid_q <= 1'b0;
      pending_pc_q    <= '0;
    end else begin
      pending_valid_q <= pending_valid_d;
      pending_pc_q    <= pending_pc_d;
    end
  end

  assign pending_valid_o = pending_valid_q;
  assign pending_pc_o    = pending_pc_q;

endmodule

// File: rtl/rv32im_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instruction-memory fetch at a time
// and hands the result to decode with a stall-able valid. Redirects (trap over
// branch) either retarget the PC at once or are parked until the outstanding
// response has been drained and discarded.
//   clk, reset          : clock, async active-high reset
//   stall_i             : decode cannot accept, hold instruction
//   redirect_*/trap_*   : PC redirect requests
//   imem                : instruction-memory bus (master side)
//   instr_valid_o/instr_o/instr_pc_o : instruction to decode
//   pc_o                : current fetch PC
//
// state | meaning
// IDLE  | first cycle after reset
// REQ   | request on bus, addr held until gnt
// WAIT  | granted, waiting for rvalid (one outstanding)
// VALID | instruction presented to decode
module rv32im_fetch_ctrl
  import rv32im_fetch_ctrl_pkg::*;
#(
  parameter int                PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_i,
  input  logic                       redirect_valid_i,
  input  logic [PC_WIDTH-1:0]        redirect_pc_i,
  input  logic                       trap_valid_i,
  input  logic [PC_WIDTH-1:0]        trap_pc_i,
  rv32im_fetch_ctrl_if.master        imem,
  output logic                       instr_valid_o,
  output logic [API_INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]        instr_pc_o,
  output logic [PC_WIDTH-1:0]        pc_o
);

  fetch_state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic [PC_WIDTH-1:0]        instr_pc_q, instr_pc_d;
  logic [API_INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                       instr_valid_q, instr_valid_d;
  // Set when the PC was retargeted in the grant cycle: the in-flight
  // response belongs to the old path and must be dropped.
  logic                       kill_q, kill_d;

  logic                redirect_now;
  logic [PC_WIDTH-1:0] target_pc;
  logic                pending_valid;
  logic [PC_WIDTH-1:0] pending_pc;
  logic                capture;
  logic                clear;

  rv32im_redirect_arb #(.PC_WIDTH(PC_WIDTH)) u_arb (
    .clk              (clk),
    .reset            (reset),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .capture_i        (capture),
    .clear_i          (clear),
    .redirect_now_o   (redirect_now),
    .target_pc_o      (target_pc),
    .pending_valid_o  (pending_valid),
    .pending_pc_o     (pending_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    kill_d        = kill_q;
    capture       = 1'b0;
    clear         = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
        if (redirect_now) pc_d = target_pc;
      end
      FETCH_REQ: begin
        if (imem.gnt) begin
          state_d = FETCH_WAIT;
          if (redirect_now) begin
            pc_d   = target_pc;
            kill_d = 1'b1;
            clear  = 1'b1;
          end
        end else if (redirect_now) begin
          // Address must stay stable until gnt; park the target.
          capture = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (imem.rvalid) begin
          state_d = FETCH_REQ;
          kill_d  = 1'b0;
          if (redirect_now) begin
            pc_d  = target_pc;
            clear = 1'b1;
          end else if (pending_valid) begin
            pc_d  = pending_pc;
            clear = 1'b1;
          end else if (!kill_q) begin
            instr_d       = imem.rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + PC_WIDTH'(4);
            state_d       = FETCH_VALID;
          end
        end else if (redirect_now) begin
          capture = 1'b1;
        end
      end
      FETCH_VALID: begin
        if (redirect_now) begin
          pc_d          = target_pc;
          instr_valid_d = 1'b0;
          state_d       = FETCH_REQ;
        end else if (!stall_i) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH_REQ;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= API_NOP;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      kill_q        <= kill_d;
    end
  end

  assign imem.req      = (state_q == FETCH_REQ);
  assign imem.addr     = pc_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_rv32im_fetch_ctrl.sv
module tb_rv32im_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        trap_valid_i;
  logic [31:0] trap_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] pc_o;

  int total = 0;
  int bad   = 0;

  rv32im_fetch_ctrl_if #(.PC_WIDTH(32)) imem ();

  rv32im_fetch_ctrl #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .imem             (imem.master),
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .pc_o             (pc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'b0, imem.req}, 32'h0);
    chk({tag, "_addr"},  imem.addr, 32'h0);
    chk({tag, "_pc"},    pc_o, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'h0);
    chk({tag, "_instr"}, instr_o, 32'h0000_0013);
    chk({tag, "_ipc"},   instr_pc_o, 32'h0);
  endtask

  // Starts in REQ at exp_addr; ends in REQ at exp_addr+4 (3 cycles).
  task automatic fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    chk({tag, "_req"},  {31'b0, imem.req}, 32'h1);
    chk({tag, "_addr"}, imem.addr, exp_addr);
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0;
    chk({tag, "_wait_req"}, {31'b0, imem.req}, 32'h0);
    imem.rvalid = 1'b1;
    imem.rdata  = data;
    tick();
    imem.rvalid = 1'b0;
    chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'h1);
    chk({tag, "_instr"}, instr_o, data);
    chk({tag, "_ipc"},   instr_pc_o, exp_addr);
    chk({tag, "_pc"},    pc_o, exp_addr + 32'd4);
    tick();
    chk({tag, "_vclr"},  {31'b0, instr_valid_o}, 32'h0);
    chk({tag, "_next"},  imem.addr, exp_addr + 32'd4);
  endtask

  initial begin
    reset = 1'b1;
    stall_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    trap_valid_i = 1'b0;
    trap_pc_i = '0;
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;

    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    chk({"idle_req"}, {31'b0, imem.req}, 32'h0);
    tick();

    // back-to-back fetches, one per 3 cycles
    fetch("f0", 32'h0, 32'hAAAA_0001);
    fetch("f1", 32'h4, 32'hAAAA_0002);
    fetch("f2", 32'h8, 32'hAAAA_0003);

    // grant delayed 3 cycles: address held
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gdly_req",  {31'b0, imem.req}, 32'h1);
      chk("gdly_addr", imem.addr, 32'hC);
    end

    // stall in VALID for 5 cycles
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata = 32'hBBBB_0004;
    stall_i = 1'b1;
    tick();
    imem.rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stl_valid", {31'b0, instr_valid_o}, 32'h1);
      chk("stl_instr", instr_o, 32'hBBBB_0004);
      chk("stl_ipc",   instr_pc_o, 32'hC);
      chk("stl_req",   {31'b0, imem.req}, 32'h0);
      tick();
    end
    stall_i = 1'b0;
    chk("stl_last_req", {31'b0, imem.req}, 32'h0);
    tick();
    chk("stl_rel_req",   {31'b0, imem.req}, 32'h1);
    chk("stl_rel_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("stl_rel_addr",  imem.addr, 32'h10);

    // trap and branch together with rvalid in WAIT: trap wins, data dropped
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata = 32'hDEAD_0001;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h100;
    trap_valid_i = 1'b1;
    trap_pc_i = 32'h200;
    tick();
    imem.rvalid = 1'b0;
    redirect_valid_i = 1'b0;
    trap_valid_i = 1'b0;
    chk("trap_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("trap_instr", instr_o, 32'hBBBB_0004);
    fetch("f200", 32'h200, 32'hCCCC_0001);

    // misaligned branch in REQ without gnt: parked until response drained
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h103;
    tick();
    redirect_valid_i = 1'b0;
    chk("rreq_addr_hold", imem.addr, 32'h204);
    chk("rreq_req_hold",  {31'b0, imem.req}, 32'h1);
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata = 32'hDEAD_0002;
    tick();
    imem.rvalid = 1'b0;
    chk("rreq_drop", {31'b0, instr_valid_o}, 32'h0);
    fetch("f100", 32'h100, 32'hCCCC_0002);

    // async reset mid-WAIT, late rvalid ignored
    imem.gnt = 1'b1;
    tick();
    imem.gnt = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst");
    imem.rvalid = 1'b1;
    imem.rdata = 32'hDEAD_0003;
    tick();
    reset = 1'b0;
    tick();
    imem.rvalid = 1'b0;
    chk("arst_late_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("arst_late_instr", instr_o, 32'h0000_0013);
    chk("arst_req",        {31'b0, imem.req}, 32'h1);

    // redirect in the grant cycle to 0xFFFFFFFC, then wrap to 0
    trap_valid_i = 1'b1;
    trap_pc_i = 32'hFFFF_FFFE;
    imem.gnt = 1'b1;
    tick();
    trap_valid_i = 1'b0;
    imem.gnt = 1'b0;
    chk("kill_pc", pc_o, 32'hFFFF_FFFC);
    imem.rvalid = 1'b1;
    imem.rdata = 32'hDEAD_0004;
    tick();
    imem.rvalid = 1'b0;
    chk("kill_drop", {31'b0, instr_valid_o}, 32'h0);
    fetch("fwrap", 32'hFFFF_FFFC, 32'hEEEE_0001);
    chk("wrap_addr", imem.addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
